// File: rtl/router1x3_core_pkg.sv
// router1x3_core_pkg
// Shared types and constants for the 1x3 byte-packet router:
//   - DATA_W / FIFO_DEPTH / SOFT_RST_CYC defaults
//   - destination address codes (ADDR_0/1/2, ADDR_INVALID)
//   - FSM state enum
//   - addr_onehot(): address code -> one-hot output select
package router1x3_core_pkg;

  localparam int DATA_W       = 8;
  localparam int FIFO_DEPTH   = 16;
  localparam int SOFT_RST_CYC = 30;
  localparam int N_PORTS      = 3;

  localparam logic [1:0] ADDR_0       = 2'd0;
  localparam logic [1:0] ADDR_1       = 2'd1;
  localparam logic [1:0] ADDR_2       = 2'd2;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    ST_DECODE,
    ST_LOAD_FIRST,
    ST_LOAD_DATA,
    ST_FULL,
    ST_LOAD_AFTER_FULL,
    ST_LOAD_PARITY,
    ST_CHECK_PARITY,
    ST_WAIT_EMPTY
  } state_t;

  // The invalid code maps to no output at all.
  function automatic logic [N_PORTS-1:0] addr_onehot(input logic [1:0] addr);
    case (addr)
      ADDR_0:  return 3'b001;
      ADDR_1:  return 3'b010;
      ADDR_2:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/router1x3_core_if.sv
// router1x3_core_if
// Bundles the router's source and consumer signals.
//   packet_valid, data_in : source byte stream (header/payload with valid=1, parity with valid=0)
//   read_enb[x]           : consumer x read request
//   data_out[x]           : FIFO x read data (one cycle after read_enb)
//   vldout[x]             : FIFO x non-empty
//   busy                  : source must hold data_in
//   err                   : parity mismatch on the last packet
// master = source/consumer side, slave = router side.
interface router1x3_core_if import router1x3_core_pkg::*; ();
  logic                            packet_valid;
  logic [DATA_W-1:0]               data_in;
  logic [N_PORTS-1:0]              read_enb;
  logic [N_PORTS-1:0][DATA_W-1:0]  data_out;
  logic [N_PORTS-1:0]              vldout;
  logic                            busy;
  logic                            err;

  modport master (
    output packet_valid, data_in, read_enb,
    input  data_out, vldout, busy, err
  );

  modport slave (
    input  packet_valid, data_in, read_enb,
    output data_out, vldout, busy, err
  );
endinterface

// File: rtl/router_fifo.sv
// router_fifo
// One output FIFO of the router with an idle-flush ("soft reset") counter.
//   clk, resetn   : clock, asynchronous active-low reset
//   i_wr_en       : write request (dropped when full or flushing)
//   i_wr_data     : write data
//   i_rd_en       : read request; o_rd_data updates at the read edge
//   o_rd_data     : registered read data, holds when not reading
//   o_empty/o_full: occupancy flags
//   o_soft_rst    : high in the cycle whose edge flushes the FIFO
module router_fifo import router1x3_core_pkg::*; #(
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int WIDTH    = DATA_W,
  parameter int SOFT_CYC = SOFT_RST_CYC
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_soft_rst
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SOFT_CYC + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [CW-1:0]    r_idle_cnt;
  logic [WIDTH-1:0] r_rd_data;

  logic w_empty, w_full, w_do_wr, w_do_rd, w_idle, w_soft_rst;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_idle     = !w_empty && !i_rd_en;
  // Flush on the edge that completes SOFT_CYC consecutive unread cycles.
  assign w_soft_rst = w_idle && (r_idle_cnt == CW'(SOFT_CYC - 1));
  assign w_do_wr    = i_wr_en && !w_full && !w_soft_rst;
  assign w_do_rd    = i_rd_en && !w_empty;

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_idle_cnt <= '0;
      r_rd_data  <= '0;
    end else begin
      if (w_soft_rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_rd) r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
      if (w_idle && !w_soft_rst) r_idle_cnt <= r_idle_cnt + CW'(1);
      else                       r_idle_cnt <= '0;
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_soft_rst = w_soft_rst;
endmodule

// File: rtl/router1x3_core.sv
// router1x3_core
// 1-input, 3-output byte-packet router: decodes the header address, streams
// header/payload/parity into the selected FIFO, checks parity and applies
// backpressure with busy.
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : router1x3_core_if slave (source stream, consumer reads,
//                 data_out/vldout per output, busy, err)
module router1x3_core import router1x3_core_pkg::*; (
  input  logic               clk,
  input  logic               resetn,
  router1x3_core_if.slave    bus
);
  state_t r_state, w_state_next;

  logic [1:0]        r_addr;
  logic [DATA_W-1:0] r_header, r_parity, r_rx_parity, r_hold;
  logic              r_hold_is_parity, r_err;

  logic [N_PORTS-1:0] w_empty, w_full, w_soft_rst, w_sel, w_dec_sel;
  logic               w_tgt_empty, w_tgt_full, w_tgt_soft, w_dec_empty, w_hdr_ok;
  logic               w_wr_en;
  logic [DATA_W-1:0]  w_wr_data;

  assign w_sel       = addr_onehot(r_addr);
  assign w_dec_sel   = addr_onehot(bus.data_in[1:0]);
  assign w_tgt_empty = |(w_empty & w_sel);
  assign w_tgt_full  = |(w_full & w_sel);
  assign w_tgt_soft  = |(w_soft_rst & w_sel);
  assign w_dec_empty = |(w_empty & w_dec_sel);
  assign w_hdr_ok    = bus.packet_valid && (bus.data_in[1:0] != ADDR_INVALID);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_DECODE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_wr_en      = 1'b0;
    w_wr_data    = bus.data_in;
    unique case (r_state)
      ST_DECODE:
        if (w_hdr_ok) w_state_next = w_dec_empty ? ST_LOAD_FIRST : ST_WAIT_EMPTY;
      ST_WAIT_EMPTY:
        if (w_tgt_empty) w_state_next = ST_LOAD_FIRST;
      ST_LOAD_FIRST: begin
        w_wr_en      = 1'b1;
        w_wr_data    = r_header;
        w_state_next = ST_LOAD_DATA;
      end
      ST_LOAD_DATA:
        if (!bus.packet_valid) w_state_next = ST_LOAD_PARITY;
        else if (w_tgt_full)   w_state_next = ST_FULL;
        else                   w_wr_en      = 1'b1;
      ST_FULL:
        if (!w_tgt_full) w_state_next = ST_LOAD_AFTER_FULL;
      ST_LOAD_AFTER_FULL: begin
        w_wr_en      = 1'b1;
        w_wr_data    = r_hold;
        w_state_next = r_hold_is_parity ? ST_CHECK_PARITY : ST_LOAD_DATA;
      end
      ST_LOAD_PARITY:
        if (w_tgt_full) w_state_next = ST_FULL;
        else begin
          w_wr_en      = 1'b1;
          w_wr_data    = r_rx_parity;
          w_state_next = ST_CHECK_PARITY;
        end
      ST_CHECK_PARITY:
        w_state_next = ST_DECODE;
      default:
        w_state_next = ST_DECODE;
    endcase
    // A flush of the FIFO being loaded abandons the packet.
    if (r_state != ST_DECODE && w_tgt_soft) begin
      w_state_next = ST_DECODE;
      w_wr_en      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr           <= '0;
      r_header         <= '0;
      r_parity         <= '0;
      r_rx_parity      <= '0;
      r_hold           <= '0;
      r_hold_is_parity <= 1'b0;
      r_err            <= 1'b0;
    end else begin
      case (r_state)
        ST_DECODE:
          if (w_hdr_ok) begin
            r_header <= bus.data_in;
            r_addr   <= bus.data_in[1:0];
            r_parity <= bus.data_in;
          end
        ST_LOAD_FIRST:
          r_err <= 1'b0;
        ST_LOAD_DATA:
          if (bus.packet_valid) begin
            // A byte parked in the hold register is still part of the packet.
            r_parity <= r_parity ^ bus.data_in;
            if (w_tgt_full) begin
              r_hold           <= bus.data_in;
              r_hold_is_parity <= 1'b0;
            end
          end else begin
            r_rx_parity <= bus.data_in;
          end
        ST_LOAD_PARITY:
          if (w_tgt_full) begin
            r_hold           <= r_rx_parity;
            r_hold_is_parity <= 1'b1;
          end
        ST_CHECK_PARITY:
          r_err <= (r_parity != r_rx_parity);
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_fifo
    logic [DATA_W-1:0] w_rd_data;
    router_fifo #(
      .DEPTH    (FIFO_DEPTH),
      .WIDTH    (DATA_W),
      .SOFT_CYC (SOFT_RST_CYC)
    ) u_fifo (
      .clk        (clk),
      .resetn     (resetn),
      .i_wr_en    (w_wr_en & w_sel[gi]),
      .i_wr_data  (w_wr_data),
      .i_rd_en    (bus.read_enb[gi]),
      .o_rd_data  (w_rd_data),
      .o_empty    (w_empty[gi]),
      .o_full     (w_full[gi]),
      .o_soft_rst (w_soft_rst[gi])
    );
    assign bus.data_out[gi] = w_rd_data;
  end

  assign bus.vldout = ~w_empty;
  assign bus.busy   = !((r_state == ST_DECODE) || (r_state == ST_LOAD_DATA));
  assign bus.err    = r_err;
endmodule

// File: tb/tb_router1x3_core.sv
// tb_router1x3_core
// Directed bench for router1x3_core: good/bad parity, invalid address,
// occupied FIFO, overflow with hold register, idle flush, mid-packet reset.
module tb_router1x3_core;
  import router1x3_core_pkg::*;

  logic clk;
  logic resetn;
  router1x3_core_if bus();

  router1x3_core dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cycles = 0;

  logic [7:0] pkt_q[$];
  logic [7:0] exp_a[$];
  logic [7:0] rxq0[$];
  logic [7:0] rxq1[$];
  logic [7:0] rxq2[$];
  logic [2:0] pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capture every byte actually read: read qualified at the edge, data sampled mid-cycle.
  initial forever begin
    @(posedge clk);
    pend = bus.read_enb & bus.vldout;
    @(negedge clk);
    if (pend[0]) rxq0.push_back(bus.data_out[0]);
    if (pend[1]) rxq1.push_back(bus.data_out[1]);
    if (pend[2]) rxq2.push_back(bus.data_out[2]);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_q();
    rxq0.delete(); rxq1.delete(); rxq2.delete();
  endtask

  // Header, L payload bytes, then XOR parity (optionally corrupted).
  task automatic make_pkt(input logic [7:0] hdr, input int seed, input bit bad);
    logic [7:0] par;
    logic [7:0] b;
    pkt_q.delete();
    pkt_q.push_back(hdr);
    par = hdr;
    for (int i = 0; i < int'(hdr[7:2]); i++) begin
      b = 8'(seed * 37 + i * 29 + 11);
      pkt_q.push_back(b);
      par = par ^ b;
    end
    if (bad) par = par ^ 8'h01;
    pkt_q.push_back(par);
    $display("pkt hdr=%02h addr=%0d len=%0d parity=%02h", hdr, hdr[1:0], hdr[7:2], par);
  endtask

  // Called mid-low-phase; returns mid-low-phase after the byte was taken.
  task automatic send_byte(input logic pv, input logic [7:0] d);
    int waited;
    waited = 0;
    bus.packet_valid = pv;
    bus.data_in      = d;
    while (bus.busy === 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
      busy_cycles++;
    end
    if (waited >= 200) check("busy_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    bus.packet_valid = 1'b0;
    bus.data_in      = 8'h00;
    while (bus.busy === 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
      busy_cycles++;
    end
    if (waited >= 200) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic send_pkt();
    for (int i = 0; i < pkt_q.size(); i++)
      send_byte(i != pkt_q.size() - 1, pkt_q[i]);
    wait_idle();
  endtask

  task automatic drain(input int x, input int n);
    $display("read port=%0d count=%0d", x, n);
    bus.read_enb[x] = 1'b1;
    repeat (n) @(negedge clk);
    bus.read_enb[x] = 1'b0;
    #1;
  endtask

  task automatic check_stream(input int x, input string tag, input logic [7:0] exp[$]);
    logic [7:0] got[$];
    case (x)
      0:       got = rxq0;
      1:       got = rxq1;
      default: got = rxq2;
    endcase
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  initial begin
    int waited;
    resetn           = 1'b0;
    bus.packet_valid = 1'b0;
    bus.data_in      = 8'h00;
    bus.read_enb     = 3'b000;

    // ---- reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_vldout", bus.vldout, 3'b000);
    check("rst_busy",   bus.busy,   1'b0);
    check("rst_err",    bus.err,    1'b0);
    check("rst_dout0",  bus.data_out[0], 8'h00);
    resetn = 1'b1;
    @(negedge clk);

    // ---- good packet, L=14 to addr 1
    clear_q();
    make_pkt(8'h39, 1, 1'b0);
    busy_cycles = 0;
    send_pkt();
    check("good_busy_cycles", busy_cycles, 3);
    check("good_vldout", bus.vldout, 3'b010);
    check("good_err", bus.err, 1'b0);
    drain(1, 16);
    check_stream(1, "good", pkt_q);
    check("good_vldout_after", bus.vldout, 3'b000);

    // ---- bad parity
    clear_q();
    make_pkt(8'h39, 4, 1'b1);
    busy_cycles = 0;
    send_pkt();
    check("bad_busy_cycles", busy_cycles, 3);
    check("bad_err", bus.err, 1'b1);
    drain(1, 16);
    check_stream(1, "bad", pkt_q);

    // ---- invalid address: ignored, err kept
    send_byte(1'b1, 8'h0B);
    bus.packet_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("inv_vldout", bus.vldout, 3'b000);
    check("inv_busy", bus.busy, 1'b0);
    check("inv_err_held", bus.err, 1'b1);

    // ---- occupied FIFO: packet A to addr 0, packet B waits for it to drain
    clear_q();
    make_pkt(8'h08, 2, 1'b0);
    send_byte(1'b1, pkt_q[0]);
    check("lf_err_held", bus.err, 1'b1);
    send_byte(1'b1, pkt_q[1]);
    check("lf_err_cleared", bus.err, 1'b0);
    send_byte(1'b1, pkt_q[2]);
    send_byte(1'b0, pkt_q[3]);
    wait_idle();
    exp_a = pkt_q;
    make_pkt(8'h04, 3, 1'b0);
    send_byte(1'b1, pkt_q[0]);
    bus.packet_valid = 1'b1;
    bus.data_in      = pkt_q[1];
    repeat (3) @(negedge clk);
    check("wait_empty_busy", bus.busy, 1'b1);
    check("wait_empty_vldout", bus.vldout, 3'b001);
    drain(0, 4);
    check_stream(0, "occ_a", exp_a);
    clear_q();
    send_byte(1'b1, pkt_q[1]);
    send_byte(1'b0, pkt_q[2]);
    wait_idle();
    drain(0, 3);
    check_stream(0, "occ_b", pkt_q);

    // ---- overflow: L=20 to addr 2, no reads until full
    clear_q();
    make_pkt(8'h52, 5, 1'b0);
    send_byte(1'b1, pkt_q[0]);
    for (int i = 1; i <= 15; i++) send_byte(1'b1, pkt_q[i]);
    check("ovf_busy_at_16", bus.busy, 1'b0);
    send_byte(1'b1, pkt_q[16]);
    check("ovf_busy_full", bus.busy, 1'b1);
    bus.data_in = pkt_q[17];
    repeat (3) @(negedge clk);
    check("ovf_busy_held", bus.busy, 1'b1);
    check("ovf_vldout", bus.vldout, 3'b100);
    drain(2, 1);
    @(negedge clk);
    @(negedge clk);
    check("ovf_released", bus.busy, 1'b0);
    send_byte(1'b1, pkt_q[17]);
    bus.read_enb[2] = 1'b1;
    for (int i = 18; i <= 20; i++) send_byte(1'b1, pkt_q[i]);
    send_byte(1'b0, pkt_q[21]);
    wait_idle();
    waited = 0;
    while (bus.vldout[2] === 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("ovf_drain_done", bus.vldout[2], 1'b0);
    bus.read_enb[2] = 1'b0;
    #1;
    check_stream(2, "ovf", pkt_q);

    // ---- idle flush of FIFO 0 while a second packet waits on it
    make_pkt(8'h0C, 6, 1'b0);
    send_pkt();
    send_byte(1'b1, 8'h0C);
    bus.packet_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("soft_busy_before", bus.busy, 1'b1);
    check("soft_vldout_before", bus.vldout[0], 1'b1);
    repeat (25) @(negedge clk);
    check("soft_vldout_after", bus.vldout[0], 1'b0);
    check("soft_busy_after", bus.busy, 1'b0);

    // ---- asynchronous reset in the middle of a packet
    make_pkt(8'h39, 7, 1'b0);
    send_byte(1'b1, pkt_q[0]);
    send_byte(1'b1, pkt_q[1]);
    send_byte(1'b0, 8'h5A);
    check("prerst_busy", bus.busy, 1'b1);
    check("prerst_vldout", bus.vldout, 3'b010);
    #2 resetn = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_vldout", bus.vldout, 3'b000);
    check("midrst_err", bus.err, 1'b0);
    check("midrst_dout0", bus.data_out[0], 8'h00);
    check("midrst_dout1", bus.data_out[1], 8'h00);
    check("midrst_dout2", bus.data_out[2], 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // ---- normal traffic after reset
    clear_q();
    make_pkt(8'h06, 9, 1'b0);
    send_pkt();
    check("post_vldout", bus.vldout, 3'b100);
    check("post_err", bus.err, 1'b0);
    drain(2, 3);
    check_stream(2, "post", pkt_q);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
